// File: rtl/sfpadd_pipe.sv
// sfpadd_pipe: multi-lane pipelined adder/subtractor for small floating point
// (SFP) words {sign, exp[expWidth-1:0], frac[sigWidth-1:0]}, bias 2^(expWidth-1)-1.
// Each lane converts both operands exactly to two's-complement fixed point,
// optionally negates b, adds, and converts back with round-to-nearest-even,
// saturation (ovf) and flush-to-zero of results below the smallest normal.
//
// Ports:
//   clk, rst            sole clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   op[LANES]           per-lane mode: 0 = a+b, 1 = a-b
//   a, b                lane i operand at [i*formatWidth +: formatWidth]
//   tag                 8-bit sideband carried with the beat
//   out_valid/out_ready result beat handshake
//   c                   per-lane result, same packing as a
//   out_tag             tag of the beat currently in c
//   ovf[LANES]          per-lane saturation flag for the beat in c
//
// Handshake: a beat moves on a rising edge when valid && ready on that channel.
// The pipe stalls as a whole when out_valid && !out_ready; in_ready is the
// combinational inverse of that stall, so every stage (bubbles included) holds
// while stalled and advances together otherwise. Sources keep valid and data
// steady until ready. Output data only changes on an advance, so c/out_tag/ovf
// stay stable while a result waits.
//
// Pipeline: input register -> ADD_LAT add registers -> output convert register.
module sfpadd_pipe #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9,
  parameter int LANES       = 4,
  parameter int ADD_LAT     = 2,
  parameter int fixWidth    = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0]             op,
  input  logic [LANES*formatWidth-1:0] a,
  input  logic [LANES*formatWidth-1:0] b,
  input  logic [7:0]                   tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*formatWidth-1:0] c,
  output logic [7:0]                   out_tag,
  output logic [LANES-1:0]             ovf
);

  localparam int EXP_MAX = 2**expWidth - 1;
  localparam logic [fixWidth-1:0] FIX_ONE  = {{(fixWidth-1){1'b0}}, 1'b1};
  // Smallest normal magnitude in fixed point: the fixed LSB equals the weight
  // of the last fraction bit at exp==1, so 1.0*2^(1-bias) is 1 << sigWidth.
  localparam logic [fixWidth-1:0] MIN_NORM = FIX_ONE << sigWidth;

  typedef logic [LANES-1:0][fixWidth-1:0] lane_fix_t;

  function automatic logic [fixWidth-1:0] fix_neg(input logic [fixWidth-1:0] x);
    return ~x + FIX_ONE;
  endfunction

  // Exact SFP -> fixed conversion. exp==0 encodes zero whatever the fraction.
  function automatic logic [fixWidth-1:0] sfp2fix(input logic [formatWidth-1:0] w);
    logic [expWidth-1:0] ex;
    logic [fixWidth-1:0] m;
    logic [fixWidth-1:0] res;
    int                  sh;
    ex = w[formatWidth-2 -: expWidth];
    m  = '0;
    m[sigWidth:0] = {1'b1, w[sigWidth-1:0]};
    sh = int'(ex) - 1;
    res = '0;
    if (ex != '0) begin
      m   = m << sh;
      res = w[formatWidth-1] ? fix_neg(m) : m;
    end
    return res;
  endfunction

  // Fixed -> SFP with RNE rounding. Returns {ovf, word}.
  function automatic logic [formatWidth:0] fix2sfp(input logic [fixWidth-1:0] x);
    logic                sgn;
    logic [fixWidth-1:0] mag;
    logic [fixWidth-1:0] mant;
    logic [fixWidth-1:0] mask;
    logic [fixWidth-1:0] rem;
    logic [fixWidth-1:0] half;
    logic                up;
    logic [formatWidth:0] res;
    int                  p;
    int                  sh;
    int                  e;
    sgn = x[fixWidth-1];
    mag = sgn ? fix_neg(x) : x;
    p = 0;
    for (int i = 0; i < fixWidth; i++) begin
      if (mag[i]) p = i;
    end
    res = '0;
    // Anything below the smallest normal has at most sigWidth significant bits,
    // so it needs no rounding and simply flushes to +0 (this also covers 0).
    if (mag >= MIN_NORM) begin
      sh   = p - sigWidth;
      mant = mag >> sh;
      mask = (FIX_ONE << sh) - FIX_ONE;
      rem  = mag & mask;
      half = mask ^ (mask >> 1);
      up   = (sh > 0) && ((rem > half) || ((rem == half) && mant[0]));
      if (up) mant = mant + FIX_ONE;
      e = p + 1 - sigWidth;
      // Rounding carried out of the mantissa: renormalise.
      if (mant[sigWidth+1]) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e > EXP_MAX) res = {1'b1, sgn, {(formatWidth-1){1'b1}}};
      else             res = {1'b0, sgn, e[expWidth-1:0], mant[sigWidth-1:0]};
    end
    return res;
  endfunction

  // Stage registers.
  logic                         s0_valid_q;
  logic [LANES-1:0]             s0_op_q;
  logic [LANES*formatWidth-1:0] s0_a_q;
  logic [LANES*formatWidth-1:0] s0_b_q;
  logic [7:0]                   s0_tag_q;

  logic      add_valid_q [ADD_LAT];
  lane_fix_t add_sum_q   [ADD_LAT];
  logic [7:0] add_tag_q  [ADD_LAT];

  logic                         out_valid_q;
  logic [LANES*formatWidth-1:0] c_q;
  logic [7:0]                   out_tag_q;
  logic [LANES-1:0]             ovf_q;

  logic                         stall;
  lane_fix_t                    sum_d;
  logic [LANES*formatWidth-1:0] c_d;
  logic [LANES-1:0]             ovf_d;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign out_tag   = out_tag_q;
  assign ovf       = ovf_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d[i] = sfp2fix(s0_a_q[i*formatWidth +: formatWidth])
               + (s0_op_q[i] ? fix_neg(sfp2fix(s0_b_q[i*formatWidth +: formatWidth]))
                             : sfp2fix(s0_b_q[i*formatWidth +: formatWidth]));
    end
  end

  always_comb begin
    c_d   = '0;
    ovf_d = '0;
    for (int i = 0; i < LANES; i++) begin
      {ovf_d[i], c_d[i*formatWidth +: formatWidth]} = fix2sfp(add_sum_q[ADD_LAT-1][i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_op_q     <= '0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s0_tag_q    <= '0;
      for (int k = 0; k < ADD_LAT; k++) begin
        add_valid_q[k] <= 1'b0;
        add_sum_q[k]   <= '0;
        add_tag_q[k]   <= '0;
      end
      out_valid_q <= 1'b0;
      c_q         <= '0;
      out_tag_q   <= '0;
      ovf_q       <= '0;
    end else if (!stall) begin
      s0_valid_q <= in_valid;
      s0_op_q    <= op;
      s0_a_q     <= a;
      s0_b_q     <= b;
      s0_tag_q   <= tag;

      add_valid_q[0] <= s0_valid_q;
      add_sum_q[0]   <= sum_d;
      add_tag_q[0]   <= s0_tag_q;
      for (int k = 1; k < ADD_LAT; k++) begin
        add_valid_q[k] <= add_valid_q[k-1];
        add_sum_q[k]   <= add_sum_q[k-1];
        add_tag_q[k]   <= add_tag_q[k-1];
      end

      out_valid_q <= add_valid_q[ADD_LAT-1];
      c_q         <= c_d;
      out_tag_q   <= add_tag_q[ADD_LAT-1];
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sfpadd_pipe.sv
// Bench for sfpadd_pipe at default parameters. Lane vectors are hand-computed
// {a, b, op, c, ovf} rows; beats are built from them and the expected
// {tag, ovf, c} is queued on acceptance and checked by an independent monitor.
module tb_sfpadd_pipe;
  localparam int FW   = 9;
  localparam int L    = 4;
  localparam int NV   = 24;
  localparam int EXPW = 8 + L + L*FW;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [L-1:0]    op;
  logic [L*FW-1:0] a;
  logic [L*FW-1:0] b;
  logic [7:0]      tag;
  logic            out_valid;
  logic            out_ready;
  logic [L*FW-1:0] c;
  logic [7:0]      out_tag;
  logic [L-1:0]    ovf;

  sfpadd_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .out_tag(out_tag), .ovf(ovf)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- lane vector table: {a, b, op, c, ovf} ----------------
  logic [28:0] vt [NV] = '{
    {9'h070, 9'h070, 1'b0, 9'h080, 1'b0},  // 1+1 = 2
    {9'h078, 9'h078, 1'b0, 9'h088, 1'b0},  // 1.5+1.5 = 3
    {9'h078, 9'h070, 1'b1, 9'h060, 1'b0},  // 1.5-1 = 0.5
    {9'h070, 9'h070, 1'b1, 9'h000, 1'b0},  // 1-1 = +0
    {9'h0FF, 9'h0FF, 1'b0, 9'h0FF, 1'b1},  // 496+496 saturates
    {9'h1FF, 9'h0FF, 1'b1, 9'h1FF, 1'b1},  // -496-496 saturates
    {9'h070, 9'h020, 1'b0, 9'h070, 1'b0},  // tie, even stays
    {9'h071, 9'h020, 1'b0, 9'h072, 1'b0},  // tie, odd rounds up
    {9'h070, 9'h028, 1'b0, 9'h071, 1'b0},  // above half rounds up
    {9'h07F, 9'h020, 1'b0, 9'h080, 1'b0},  // round carries into exponent
    {9'h0FF, 9'h0A0, 1'b0, 9'h0FF, 1'b1},  // 504 rounds to 512 -> saturate
    {9'h0FF, 9'h090, 1'b0, 9'h0FF, 1'b0},  // 500 rounds to 496, no ovf
    {9'h011, 9'h010, 1'b1, 9'h000, 1'b0},  // tiny difference flushes
    {9'h011, 9'h000, 1'b0, 9'h011, 1'b0},  // smallest normals survive
    {9'h00F, 9'h070, 1'b0, 9'h070, 1'b0},  // exp 0 is zero
    {9'h070, 9'h078, 1'b1, 9'h160, 1'b0},  // 1-1.5 = -0.5
    {9'h170, 9'h170, 1'b0, 9'h180, 1'b0},  // -1-1 = -2
    {9'h010, 9'h010, 1'b0, 9'h020, 1'b0},  // 2^-6+2^-6
    {9'h100, 9'h100, 1'b0, 9'h000, 1'b0},  // -0 + -0 = +0
    {9'h0FF, 9'h0FE, 1'b1, 9'h0B0, 1'b0},  // 496-480 = 16
    {9'h080, 9'h011, 1'b1, 9'h080, 1'b0},  // 2-17/1024 rounds back to 2
    {9'h1FF, 9'h1FF, 1'b0, 9'h1FF, 1'b1},  // negative saturation via add
    {9'h070, 9'h170, 1'b0, 9'h000, 1'b0},  // 1 + -1 = +0
    {9'h160, 9'h060, 1'b1, 9'h170, 1'b0}   // -0.5-0.5 = -1
  };

  // ---------------- scoreboard state ----------------
  logic [EXPW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int lane_idx [L];
  int acc_cyc = 0;
  int mode = 0;        // out_ready pattern: 0 always, 1 stall window, 2 random
  int stall_base = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, req, cyc);
    end
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] t, input bit chk);
    logic [L*FW-1:0] av, bv, ec;
    logic [L-1:0]    opv, eo;
    logic [28:0]     row;
    int              budget;
    for (int i = 0; i < L; i++) begin
      row = vt[lane_idx[i]];
      av[i*FW +: FW] = row[28:20];
      bv[i*FW +: FW] = row[19:11];
      opv[i]         = row[10];
      ec[i*FW +: FW] = row[9:1];
      eo[i]          = row[0];
    end
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; op = opv; tag = t;
    #1;
    budget = 200;
    while (!in_ready) begin
      if (budget == 0) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
        report();
      end
      budget--;
      @(negedge clk); #1;
    end
    acc_cyc = cyc;
    if (chk) exp_q.push_back({t, eo, ec});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic lat_check();
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      check($sformatf("latency_d%0d", d), 64'(out_valid), 64'(d == 4));
    end
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- out_ready pattern + stall-window in_ready check ----------------
  initial begin
    int k;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (mode)
        1: begin
          k = cyc - stall_base;
          out_ready = !(k >= 5 && k <= 8);
        end
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (mode == 1 && k >= 4 && k <= 9) begin
        #2;
        check($sformatf("in_ready_k%0d", k), 64'(in_ready), 64'(!(k >= 5 && k <= 8)));
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EXPW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: tag %h c %h with nothing expected", out_tag, c);
        end else begin
          e = exp_q.pop_front();
          check("result_c",   64'(c),       64'(e[L*FW-1:0]));
          check("result_ovf", 64'(ovf),     64'(e[L*FW +: L]));
          check("result_tag", 64'(out_tag), 64'(e[EXPW-1 -: 8]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    n_cmp++; n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;  // offered during reset; must not be taken
    a = {9'h070, 9'h070, 9'h078, 9'h078};
    b = a;
    op = '0;
    tag = 8'hEE;
    repeat (3) @(negedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_c",         64'(c),         64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      check("no_accept_in_rst", 64'(out_valid), 64'd0);
    end

    // Single beat: REQ example vectors in lanes 0..3, latency 4.
    for (int i = 0; i < L; i++) lane_idx[i] = i;
    send(8'h5A, 1'b1);
    lat_check();
    drain();

    // Whole table back to back at full rate.
    for (int j = 0; j < NV/L; j++) begin
      for (int i = 0; i < L; i++) lane_idx[i] = j*L + i;
      send(8'(16 + j), 1'b1);
    end
    idle();
    drain();

    // Ten-beat stream with out_ready low during stream cycles 5..8.
    @(negedge clk); #3;
    stall_base = cyc + 1;
    mode = 1;
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < L; i++) lane_idx[i] = (j*L + i + 1) % NV;
      send(8'(8'hA0 + j), 1'b1);
    end
    idle();
    drain();
    mode = 0;

    // Reset with three beats in flight.
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < L; i++) lane_idx[i] = (j + i*5) % NV;
      send(8'(8'h70 + j), 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;  // in_valid still high: that beat must be dropped
    @(negedge clk); #2;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_c",         64'(c),         64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      check("no_stale_after_rst", 64'(out_valid), 64'd0);
    end
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    for (int i = 0; i < L; i++) lane_idx[i] = 4 + i;
    send(8'hC3, 1'b1);
    lat_check();
    drain();

    // Random table rows per lane, random gaps and random backpressure.
    mode = 2;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < L; i++) lane_idx[i] = $urandom_range(0, NV-1);
      send(8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    mode = 0;

    repeat (3) @(negedge clk);
    report();
  end

endmodule

// File: doc/sfpadd_pipe.md
SFPADD_PIPE -- requirements
Module: sfpadd_pipe

Interface
REQ-001 The block SHALL have parameter expWidth, default 4, meaning SFP exponent field width.
REQ-002 The block SHALL have parameter sigWidth, default 4, meaning SFP fraction field width (hidden bit excluded).
REQ-003 The block SHALL have parameter formatWidth, default 9, meaning 1+expWidth+sigWidth.
REQ-004 The block SHALL have parameter LANES, default 4, meaning independent adder lanes per transaction.
REQ-005 The block SHALL have parameter ADD_LAT, default 2, meaning registered stages in the fixed-point add (>=1).
REQ-006 The block SHALL have parameter fixWidth, default 21, meaning internal two's-complement fixed width.
REQ-007 Port clk, input, 1, sole clock; all state on rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port in_valid, input, 1, input beat offered.
REQ-010 Port in_ready, output, 1, block accepts beat this cycle.
REQ-011 Port op, input, LANES, per-lane mode: 0 = a+b, 1 = a-b.
REQ-012 Port a, input, LANES*formatWidth, lane i operand at bits [i*formatWidth +: formatWidth].
REQ-013 Port b, input, LANES*formatWidth, same packing as a.
REQ-014 Port tag, input, 8, opaque sideband carried with the beat.
REQ-015 Port out_valid, output, 1, result beat present.
REQ-016 Port out_ready, input, 1, downstream accepts result.
REQ-017 Port c, output, LANES*formatWidth, per-lane result, same packing as a.
REQ-018 Port out_tag, output, 8, tag of the beat in c.
REQ-019 Port ovf, output, LANES, per-lane saturation flag for the beat in c.

Function
REQ-020 SFP word SHALL be {sign, exp[expWidth-1:0], frac[sigWidth-1:0]}, sign-magnitude, bias 2^(expWidth-1)-1 (7 at default), value (-1)^s*1.frac*2^(exp-bias); exp==0 SHALL be zero regardless of frac.
REQ-021 Each lane SHALL convert a and b to fixWidth fixed point exactly via sfp2fix, negate b when op[i]=1, add, and convert back.
REQ-022 Back-conversion SHALL round to nearest, ties to even; fixed zero SHALL yield 9'h000 (+0).
REQ-023 Magnitude above max finite SHALL saturate to {sign, all-ones exp, all-ones frac} and set ovf[i]; otherwise ovf[i]=0.
REQ-024 Magnitude below 2^(1-bias) after rounding SHALL flush to +0 with ovf[i]=0.
REQ-025 A beat SHALL be accepted when in_valid && in_ready; a result SHALL transfer when out_valid && out_ready.
REQ-026 Pipeline depth SHALL be ADD_LAT+2 stages: input register, ADD_LAT add stages, output convert register; unstalled latency accept-to-out_valid SHALL be ADD_LAT+2 cycles.
REQ-027 Each stage SHALL carry a valid bit; op, tag travel aligned with their data.
REQ-028 Stall SHALL be out_valid && !out_ready; during stall every stage SHALL hold, no beat lost or duplicated.
REQ-029 in_ready SHALL be !stall (combinational); bubbles SHALL advance only when not stalled.
REQ-030 Full throughput SHALL be one beat per cycle with out_ready held high.
REQ-031 c, out_tag, ovf SHALL be stable while out_valid && !out_ready.
REQ-032 Beats SHALL exit in acceptance order; lanes SHALL never mix beats.
REQ-033 in_valid with in_ready=0 SHALL be ignored; source holds it.

Reset
REQ-034 While rst=1 all stage valid bits, out_valid, c, out_tag, ovf SHALL be 0 on the next edge; in_ready SHALL be 1 after reset.
REQ-035 rst mid-operation SHALL discard all in-flight beats; a beat offered during rst SHALL NOT be accepted.

Verification
REQ-036 Lane0 a=0x070, b=0x070, op=0, tag=0x5A, out_ready=1 -> after 4 cycles (ADD_LAT=2) c lane0=0x080, out_tag=0x5A, ovf=0.
REQ-037 Lane1 a=0x078, b=0x078, op=0 -> 0x088; lane2 a=0x078, b=0x070, op=1 -> 0x060 (0.5); lane3 a=b=0x070, op=1 -> 0x000.
REQ-038 a=0x0FF, b=0x0FF, op=0 -> c=0x0FF, ovf=1; a=0x1FF, b=0x0FF, op=1 -> c=0x1FF, ovf=1.
REQ-039 Stream 10 beats back-to-back, out_ready low cycles 5-8 -> in_ready low those cycles, all 10 results in order with correct tags, none dropped.
REQ-040 Assert rst with 3 beats in flight -> out_valid=0 next cycle, no stale result after rst release; next beat returns after 4 cycles.
REQ-041 Random a, b, op all lanes vs golden model with random out_ready -> bit-exact c, ovf, order.
